// File: rtl/smem_row_loader.sv
// Row loader feeding the HSI SMEM row writer: packs four AXI-Stream beats into one
// 256-byte row and hands rows to the writer through a two-deep ping-pong buffer.
module smem_row_loader #(
    parameter int DW = 512
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   cfg_first_row,
    input  logic [31:0]   cfg_row_count,
    input  logic          cfg_start,
    output logic          busy,
    output logic          complete,
    output logic [31:0]   rows_sent,
    output logic          framing_error,
    input  logic [DW-1:0] axis_tdata,
    input  logic          axis_tlast,
    input  logic          axis_tvalid,
    output logic          axis_tready,
    output logic [DW-1:0] smem_data0,
    output logic [DW-1:0] smem_data1,
    output logic [DW-1:0] smem_data2,
    output logic [DW-1:0] smem_data3,
    output logic [31:0]   row_index,
    output logic          start,
    input  logic          ready,
    input  logic          done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [31:0]  count_q, count_d;
    logic [31:0]  row_index_q, row_index_d;
    logic [31:0]  rows_sent_q, rows_sent_d;
    logic [31:0]  rows_loaded_q, rows_loaded_d;
    logic         fill_sel_q, fill_sel_d;
    logic [1:0]   fill_beat_q, fill_beat_d;
    logic [1:0]   full_q, full_d;
    logic         send_sel_q, send_sel_d;
    logic         in_flight_q, in_flight_d;
    logic         start_q, start_d;
    logic         framing_error_q, framing_error_d;
    logic         complete_q, complete_d;

    logic [DW-1:0] row_buf_q [2][4];

    logic tready_s;
    logic accept_s;
    logic last_beat_s;
    logic issue_s;
    logic release_s;

    // The fill buffer is writable only while empty and rows remain to be loaded.
    assign tready_s    = (state_q == ST_RUN) && !full_q[fill_sel_q] && (rows_loaded_q != count_q);
    assign accept_s    = axis_tvalid && tready_s;
    assign last_beat_s = (fill_beat_q == 2'd3);
    assign issue_s     = (state_q == ST_RUN) && !in_flight_q && !start_q && full_q[send_sel_q] && ready;
    // ready is forced low by the writer while start is high, so wait for start to drop first
    assign release_s   = in_flight_q && !start_q && ready;

    // Next-state logic for the job FSM, fill side and issue side.
    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        row_index_d     = row_index_q;
        rows_sent_d     = rows_sent_q;
        rows_loaded_d   = rows_loaded_q;
        fill_sel_d      = fill_sel_q;
        fill_beat_d     = fill_beat_q;
        full_d          = full_q;
        send_sel_d      = send_sel_q;
        in_flight_d     = in_flight_q;
        start_d         = 1'b0;
        framing_error_d = framing_error_q;
        complete_d      = 1'b0;

        if (accept_s) begin
            fill_beat_d = fill_beat_q + 2'd1;
            if (axis_tlast != last_beat_s) begin
                framing_error_d = 1'b1;
            end else begin
                framing_error_d = framing_error_q;
            end
            if (last_beat_s) begin
                full_d[fill_sel_q] = 1'b1;
                fill_sel_d         = ~fill_sel_q;
                rows_loaded_d      = rows_loaded_q + 32'd1;
            end else begin
                fill_sel_d         = fill_sel_q;
            end
        end else begin
            fill_beat_d = fill_beat_q;
        end

        if (issue_s) begin
            start_d     = 1'b1;
            in_flight_d = 1'b1;
        end else if (release_s) begin
            full_d[send_sel_q] = 1'b0;
            send_sel_d         = ~send_sel_q;
            rows_sent_d        = rows_sent_q + 32'd1;
            row_index_d        = row_index_q + 32'd1;
            in_flight_d        = 1'b0;
        end else begin
            in_flight_d = in_flight_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_start && (cfg_row_count != 32'd0)) begin
                    state_d         = ST_RUN;
                    count_d         = cfg_row_count;
                    row_index_d     = cfg_first_row;
                    rows_sent_d     = 32'd0;
                    rows_loaded_d   = 32'd0;
                    fill_sel_d      = 1'b0;
                    fill_beat_d     = 2'd0;
                    full_d          = 2'b00;
                    send_sel_d      = 1'b0;
                    in_flight_d     = 1'b0;
                    framing_error_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (rows_sent_q == count_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (done) begin
                    complete_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d    = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            count_q         <= 32'd0;
            row_index_q     <= 32'd0;
            rows_sent_q     <= 32'd0;
            rows_loaded_q   <= 32'd0;
            fill_sel_q      <= 1'b0;
            fill_beat_q     <= 2'd0;
            full_q          <= 2'b00;
            send_sel_q      <= 1'b0;
            in_flight_q     <= 1'b0;
            start_q         <= 1'b0;
            framing_error_q <= 1'b0;
            complete_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            row_index_q     <= row_index_d;
            rows_sent_q     <= rows_sent_d;
            rows_loaded_q   <= rows_loaded_d;
            fill_sel_q      <= fill_sel_d;
            fill_beat_q     <= fill_beat_d;
            full_q          <= full_d;
            send_sel_q      <= send_sel_d;
            in_flight_q     <= in_flight_d;
            start_q         <= start_d;
            framing_error_q <= framing_error_d;
            complete_q      <= complete_d;
        end
    end

    // Row buffer storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            row_buf_q[fill_sel_q][fill_beat_q] <= axis_tdata;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign complete      = complete_q;
    assign rows_sent     = rows_sent_q;
    assign framing_error = framing_error_q;
    assign axis_tready   = tready_s;
    assign row_index     = row_index_q;
    assign start         = start_q;
    assign smem_data0    = row_buf_q[send_sel_q][0];
    assign smem_data1    = row_buf_q[send_sel_q][1];
    assign smem_data2    = row_buf_q[send_sel_q][2];
    assign smem_data3    = row_buf_q[send_sel_q][3];

endmodule

// File: tb/tb_smem_row_loader.sv
// Randomized bench for smem_row_loader with a behavioural writer and row scoreboard.
module tb_smem_row_loader;
    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   cfg_first_row, cfg_row_count;
    logic          cfg_start;
    logic          busy, complete, framing_error;
    logic [31:0]   rows_sent, row_index;
    logic [DW-1:0] axis_tdata;
    logic          axis_tlast, axis_tvalid, axis_tready;
    logic [DW-1:0] smem_data0, smem_data1, smem_data2, smem_data3;
    logic          start, ready, done;

    int n_checks = 0;
    int n_fail   = 0;

    // writer model state
    int wr_lat   = 0;
    bit wr_hold  = 1'b0;
    int wr_cnt   = 0;
    bit pend     = 1'b0;
    int released = 0;

    // scoreboard state
    logic [31:0]   cap_idx [128];
    logic [DW-1:0] cap_d   [128][4];
    int            cap_n = 0;
    logic [DW-1:0] exp_d   [64][4];
    int            beats_acc = 0;
    int            rel_base  = 0;

    smem_row_loader #(.DW(DW)) dut (
        .clk(clk), .reset(reset),
        .cfg_first_row(cfg_first_row), .cfg_row_count(cfg_row_count), .cfg_start(cfg_start),
        .busy(busy), .complete(complete), .rows_sent(rows_sent), .framing_error(framing_error),
        .axis_tdata(axis_tdata), .axis_tlast(axis_tlast), .axis_tvalid(axis_tvalid),
        .axis_tready(axis_tready),
        .smem_data0(smem_data0), .smem_data1(smem_data1), .smem_data2(smem_data2),
        .smem_data3(smem_data3),
        .row_index(row_index), .start(start), .ready(ready), .done(done)
    );

    always #5 clk = ~clk;

    assign ready = !start && (wr_cnt == 0) && !wr_hold;
    assign done  = ready;

    // Writer: busy for wr_lat cycles after each start; a row counts as released on the
    // first cycle after start where the writer reports ready.
    always @(posedge clk) begin
        if (reset) begin
            wr_cnt <= 0;
            pend   <= 1'b0;
        end else if (start) begin
            wr_cnt <= wr_lat;
            pend   <= 1'b1;
        end else begin
            if (wr_cnt != 0) wr_cnt <= wr_cnt - 1;
            if (pend && ready) begin
                pend     <= 1'b0;
                released <= released + 1;
            end
        end
    end

    // Capture every row handed to the writer.
    always @(negedge clk) begin
        if (!reset && start) begin
            cap_idx[cap_n % 128]    <= row_index;
            cap_d[cap_n % 128][0]   <= smem_data0;
            cap_d[cap_n % 128][1]   <= smem_data1;
            cap_d[cap_n % 128][2]   <= smem_data2;
            cap_d[cap_n % 128][3]   <= smem_data3;
            cap_n                   <= cap_n + 1;
        end
    end

    task automatic pulse_cfg(input logic [31:0] first, input logic [31:0] count);
        @(negedge clk);
        cfg_first_row = first;
        cfg_row_count = count;
        cfg_start     = 1'b1;
        @(negedge clk);
        cfg_start     = 1'b0;
    endtask

    // Offer one beat; tready must be low exactly when both row buffers hold unsent rows.
    task automatic push_beat(input logic [DW-1:0] d, input logic last);
        int t;
        int occ;
        logic exp_tr;
        axis_tvalid = 1'b0;
        repeat ($urandom_range(0, 1)) @(negedge clk);
        axis_tdata  = d;
        axis_tlast  = last;
        axis_tvalid = 1'b1;
        t = 0;
        forever begin
            occ    = beats_acc / 4 - (released - rel_base);
            exp_tr = (occ < 2);
            n_checks++;
            if (axis_tready !== exp_tr) begin
                n_fail++;
                $display("FAIL tready_rule: got %b want %b (full rows %0d)", axis_tready, exp_tr, occ);
            end
            if (axis_tready === 1'b1) begin
                @(negedge clk);
                beats_acc++;
                break;
            end
            t++;
            if (t >= 500) begin
                n_fail++;
                $display("FAIL beat_timeout: got no tready want tready within 500 cycles");
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic make_rows(input int count);
        logic [DW-1:0] w;
        for (int r = 0; r < count; r++) begin
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < DW / 32; j++) w[32*j +: 32] = $urandom;
                exp_d[r][k] = w;
            end
        end
    endtask

    task automatic run_job(input logic [31:0] first, input int count, input int lat,
                           input int bad_row, input bit hold, input bit poke);
        int cap_base;
        int t;
        logic exp_fe;
        wr_lat    = lat;
        rel_base  = released;
        cap_base  = cap_n;
        beats_acc = 0;
        exp_fe    = (bad_row >= 0);
        make_rows(count);
        pulse_cfg(first, count);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL job_busy: got %b want 1", busy); end
        n_checks++;
        if (framing_error !== 1'b0) begin n_fail++; $display("FAIL fe_clear: got %b want 0", framing_error); end
        n_checks++;
        if (row_index !== first) begin n_fail++; $display("FAIL idx_init: got %h want %h", row_index, first); end
        n_checks++;
        if (rows_sent !== 32'd0) begin n_fail++; $display("FAIL sent_init: got %0d want 0", rows_sent); end
        if (poke) pulse_cfg(32'h0000_0ABC, 32'd7);
        if (hold) wr_hold = 1'b1;
        for (int r = 0; r < count; r++) begin
            for (int k = 0; k < 4; k++) begin
                if (hold && beats_acc == 8) begin
                    axis_tvalid = 1'b1;
                    for (int c = 0; c < 3; c++) begin
                        n_checks++;
                        if (axis_tready !== 1'b0 || start !== 1'b0) begin
                            n_fail++;
                            $display("FAIL hold_stall: got tready=%b start=%b want 0/0", axis_tready, start);
                        end
                        @(negedge clk);
                    end
                    wr_hold = 1'b0;
                end
                push_beat(exp_d[r][k], (k == 3) || (r == bad_row && k == 1));
            end
        end
        axis_tvalid = 1'b0;
        axis_tlast  = 1'b0;
        wr_hold     = 1'b0;
        t = 0;
        while (complete !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (t >= 3000) begin n_fail++; $display("FAIL complete_timeout: got none want pulse"); end
        n_checks++;
        if (rows_sent !== count) begin n_fail++; $display("FAIL rows_sent: got %0d want %0d", rows_sent, count); end
        n_checks++;
        if (framing_error !== exp_fe) begin n_fail++; $display("FAIL framing: got %b want %b", framing_error, exp_fe); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
        @(negedge clk);
        n_checks++;
        if (complete !== 1'b0) begin n_fail++; $display("FAIL complete_width: got %b want 0", complete); end
        n_checks++;
        if (cap_n - cap_base !== count) begin
            n_fail++;
            $display("FAIL start_count: got %0d want %0d", cap_n - cap_base, count);
        end
        for (int r = 0; r < count && r < cap_n - cap_base; r++) begin
            n_checks++;
            if (cap_idx[(cap_base + r) % 128] !== first + r) begin
                n_fail++;
                $display("FAIL row_index: got %h want %h", cap_idx[(cap_base + r) % 128], first + r);
            end
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (cap_d[(cap_base + r) % 128][k] !== exp_d[r][k]) begin
                    n_fail++;
                    $display("FAIL row_data r%0d b%0d: got %h want %h", r, k,
                             cap_d[(cap_base + r) % 128][k], exp_d[r][k]);
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        n_checks++;
        if (busy !== 1'b0 || complete !== 1'b0 || rows_sent !== 32'd0 || framing_error !== 1'b0 ||
            axis_tready !== 1'b0 || start !== 1'b0 || row_index !== 32'd0) begin
            n_fail++;
            $display("FAIL %s: got busy=%b cmp=%b sent=%0d fe=%b trdy=%b start=%b idx=%h want all 0",
                     tag, busy, complete, rows_sent, framing_error, axis_tready, start, row_index);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_hold");
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_release");
    endtask

    task automatic test_single_row();
        run_job(32'h0000_0010, 1, 0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_slow_writer();
        run_job(32'h0000_0010, 5, 70, -1, 1'b0, 1'b0);
    endtask

    task automatic test_writer_held();
        run_job(32'h0000_0040, 3, 0, -1, 1'b1, 1'b0);
    endtask

    task automatic test_framing();
        run_job(32'h0000_0050, 2, 2, 0, 1'b0, 1'b0);
        run_job(32'h0000_0060, 1, 0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midjob();
        wr_lat    = 10;
        rel_base  = released;
        beats_acc = 0;
        make_rows(3);
        pulse_cfg(32'h0000_0020, 32'd4);
        for (int b = 0; b < 9; b++) push_beat(exp_d[b / 4][b % 4], (b % 4) == 3);
        reset = 1'b1;
        #1;
        check_idle_outputs("reset_midjob");
        @(negedge clk);
        reset       = 1'b0;
        axis_tvalid = 1'b0;
        axis_tlast  = 1'b0;
        repeat (12) @(negedge clk);
        check_idle_outputs("after_midjob_reset");
        run_job(32'h0000_0030, 2, 3, -1, 1'b0, 1'b0);
    endtask

    task automatic test_ignored_starts();
        pulse_cfg(32'h0000_0055, 32'd0);
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (busy !== 1'b0 || axis_tready !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_count: got busy=%b tready=%b want 0/0", busy, axis_tready);
            end
            @(negedge clk);
        end
        run_job(32'h0000_0070, 2, 5, -1, 1'b0, 1'b1);
    endtask

    task automatic test_index_wrap();
        run_job(32'hFFFF_FFFF, 2, 4, -1, 1'b0, 1'b0);
    endtask

    initial begin
        reset         = 1'b1;
        cfg_first_row = 32'd0;
        cfg_row_count = 32'd0;
        cfg_start     = 1'b0;
        axis_tdata    = '0;
        axis_tlast    = 1'b0;
        axis_tvalid   = 1'b0;
        test_reset();
        test_single_row();
        test_slow_writer();
        test_writer_held();
        test_framing();
        test_reset_midjob();
        test_ignored_starts();
        test_index_wrap();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got still running want finished");
        $fatal(1, "global timeout");
    end
endmodule
